menu_text_fetch: RTL and testbench

Read-side controller for the 2 KiB menu RAM (2048×8, dual-port). It owns port B and turns the text buffer plus 8×8 font held in that RAM into a 1-bit-per-pixel menu overlay stream. It schedules two RAM reads per character cell, a character code and then a font row, one cell ahead of the beam. Port A stays with the menu CPU/loader for writes.

---
 rtl/menu_text_fetch.sv | 129 ++++++++++++
 tb/tb_menu_text_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_text_fetch.sv
// Menu overlay read-side controller: fetches a character code and a font row per text cell
// from the menu RAM port B and serialises them into a 1-bpp overlay pixel stream.
module menu_text_fetch #(
   parameter logic [10:0] TEXT_BASE = 11'h000,
   parameter logic [10:0] FONT_BASE = 11'h400,
   parameter int unsigned COLS      = 32,
   parameter int unsigned ROWS      = 28
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_ce,
   input  logic        de,
   input  logic [7:0]  x,
   input  logic [7:0]  y,
   input  logic        line_start,
   input  logic        sel_en,
   input  logic [4:0]  sel_row,
   input  logic [7:0]  ram_doutb,
   output logic [10:0] ram_adb,
   output logic        ram_ceb,
   output logic        ram_oceb,
   output logic        ram_wreb,
   output logic        pix_out,
   output logic        pix_valid,
   output logic        overrun
);

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned Y_END  = ROWS * 8;

   typedef enum logic [2:0] {IDLE, CHAR, CODE, FONT, DATA} state_t;

   state_t      state;
   logic        code_inv;
   logic [7:0]  next_bits;
   logic        next_inv;
   logic [7:0]  shift;
   logic        cell_inv;

   logic              in_rows;
   logic              in_cols;
   logic              load;
   logic              req_line;
   logic              req_pix;
   logic              req;
   logic [4:0]        req_col;
   logic [ADDR_W-1:0] char_addr;
   logic [ADDR_W-1:0] font_addr;
   logic              pix_bit;
   logic              pix_inv;
   logic              row_inv;

   assign ram_oceb = 1'b1;
   assign ram_wreb = 1'b0;

   // Request decode, fetch addresses and the pixel selected this pix_ce (post-load view)
   always_comb begin
      in_rows   = {1'b0, y} < 9'(Y_END);
      in_cols   = {1'b0, x[7:3]} < 6'(COLS);
      load      = pix_ce & de & (x[2:0] == 3'd0);
      req_line  = line_start & in_rows;
      req_pix   = load & in_rows & ({1'b0, x[7:3]} < 6'(COLS - 1));
      req       = req_line | req_pix;
      req_col   = req_line ? 5'd0 : x[7:3] + 5'd1;
      char_addr = TEXT_BASE + ADDR_W'(y[7:3]) * ADDR_W'(COLS) + ADDR_W'(req_col);
      // Code byte is on ram_doutb during CODE, so the font row address is formed from it directly
      font_addr = FONT_BASE + ADDR_W'({ram_doutb[6:0], 3'b000}) + ADDR_W'(y[2:0]);
      pix_bit   = load ? next_bits[0] : shift[1];
      pix_inv   = load ? next_inv : cell_inv;
      row_inv   = sel_en & (y[7:3] == sel_row);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ram_adb   <= '0;
         ram_ceb   <= 1'b0;
         code_inv  <= 1'b0;
         next_bits <= '0;
         next_inv  <= 1'b0;
         shift     <= '0;
         cell_inv  <= 1'b0;
         pix_out   <= 1'b0;
         pix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pix_valid <= pix_ce;
         pix_out   <= pix_ce & de & in_rows & in_cols & (pix_bit ^ pix_inv ^ row_inv);

         if (pix_ce & de) begin
            if (load) begin
               shift    <= next_bits;
               cell_inv <= next_inv;
            end else begin
               shift <= shift >> 1;
            end
         end

         ram_ceb <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  state   <= CHAR;
                  ram_adb <= char_addr;
                  ram_ceb <= 1'b1;
               end
            end
            CHAR: state <= CODE;
            CODE: begin
               code_inv <= ram_doutb[7];
               ram_adb  <= font_addr;
               ram_ceb  <= 1'b1;
               state    <= FONT;
            end
            FONT: state <= DATA;
            DATA: begin
               next_bits <= ram_doutb;
               next_inv  <= code_inv;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Busy FSM cannot accept another cell; flag it permanently
         if (req && (state != IDLE)) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_menu_text_fetch.sv
// Directed bench for menu_text_fetch: RAM model, address and pixel scoreboards, reset/overrun checks.
module tb_menu_text_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_ce;
   logic        de;
   logic [7:0]  x;
   logic [7:0]  y;
   logic        line_start;
   logic        sel_en;
   logic [4:0]  sel_row;
   logic [7:0]  ram_doutb;
   logic [10:0] ram_adb;
   logic        ram_ceb;
   logic        ram_oceb;
   logic        ram_wreb;
   logic        pix_out;
   logic        pix_valid;
   logic        overrun;

   logic [7:0]  mem [0:2047];
   int          compared   = 0;
   int          mismatched = 0;
   int          addr_q[$];
   int          pix_q[$];

   int exp_plain [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
   int exp_inv   [8] = '{1, 1, 0, 0, 1, 1, 1, 1};

   always #5 clk = ~clk;

   menu_text_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .pix_ce     (pix_ce),
      .de         (de),
      .x          (x),
      .y          (y),
      .line_start (line_start),
      .sel_en     (sel_en),
      .sel_row    (sel_row),
      .ram_doutb  (ram_doutb),
      .ram_adb    (ram_adb),
      .ram_ceb    (ram_ceb),
      .ram_oceb   (ram_oceb),
      .ram_wreb   (ram_wreb),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid),
      .overrun    (overrun)
   );

   // Synchronous-read RAM port B
   always @(posedge clk) if (ram_ceb) ram_doutb <= mem[ram_adb];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pix(input int px, input int py, input logic pde);
      int code, font, b, rinv;
      if (!pde || py >= 224) return 0;
      code = int'(mem[(py / 8) * 32 + px / 8]);
      font = int'(mem[(1024 + (code % 128) * 8 + py % 8) % 2048]);
      b    = (font >> (px % 8)) & 1;
      rinv = (sel_en && (py / 8 == int'(sel_row))) ? 1 : 0;
      return b ^ (code / 128) ^ rinv;
   endfunction

   task automatic push_fetch(input int col, input int py);
      int a, c;
      a = (py / 8) * 32 + col;
      c = int'(mem[a]);
      addr_q.push_back(a);
      addr_q.push_back((1024 + (c % 128) * 8 + py % 8) % 2048);
   endtask

   task automatic drive_pix(input int px, input logic pde, input int exp);
      x = 8'(px);
      de = pde;
      pix_q.push_back(exp);
      pix_ce = 1'b1;
      tick();
      pix_ce = 1'b0;
      tick();
   endtask

   task automatic start_line(input int py, input bit push);
      y = 8'(py);
      if (push) push_fetch(0, py);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      repeat (6) tick();
   endtask

   task automatic sweep(input int py, input int lo, input int hi, input logic pde);
      for (int i = lo; i <= hi; i++) begin
         if (pde && py < 224 && i % 8 == 0 && i / 8 < 31) push_fetch(i / 8 + 1, py);
         drive_pix(i, pde, model_pix(i, py, pde));
      end
   endtask

   // Scoreboard side: compare fetch addresses and pixels as the DUT emits them
   always @(negedge clk) begin
      int e;
      if (ram_ceb) begin
         if (addr_q.size() == 0) check("no_fetch_expected", 32'(ram_ceb), 32'd0);
         else check("fetch_addr", 32'(ram_adb), 32'(addr_q.pop_front()));
      end
      if (pix_valid) begin
         if (pix_q.size() == 0) check("no_pixel_expected", 32'(pix_valid), 32'd0);
         else begin
            e = pix_q.pop_front();
            if (e >= 0) check("pix_out", 32'(pix_out), 32'(e));
         end
      end else begin
         check("pix_idle", 32'(pix_out), 32'd0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; pix_ce = 1'b0; de = 1'b0; x = '0; y = '0;
      line_start = 1'b0; sel_en = 1'b0; sel_row = '0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) mem[16'h500 + i] = 8'h00;
      mem[0]      = 8'h41;
      mem[16'h608] = 8'h0C;
      mem[16'h040] = 8'h20;
      tick(); tick();

      check("rst_adb", 32'(ram_adb), 32'd0);
      check("rst_ceb", 32'(ram_ceb), 32'd0);
      check("rst_pix_out", 32'(pix_out), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("oceb_tie", 32'(ram_oceb), 32'd1);
      check("wreb_tie", 32'(ram_wreb), 32'd0);
      reset = 1'b0;
      tick();

      // Glyph row 0 of code 0x41
      addr_q.push_back(0); addr_q.push_back(16'h608);
      start_line(0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) push_fetch(1, 0);
         drive_pix(i, 1'b1, exp_plain[i]);
      end

      // Attribute bit inverts the cell but not the font address
      mem[0] = 8'hC1;
      addr_q.push_back(0); addr_q.push_back(16'h608);
      start_line(0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) push_fetch(1, 0);
         drive_pix(i, 1'b1, exp_inv[i]);
      end

      // de low: no pixels, no per-cell fetch
      start_line(0, 1);
      sweep(0, 0, 15, 1'b0);

      // Highlighted row over a blank glyph
      sel_en = 1'b1; sel_row = 5'd2;
      start_line(16, 1);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) push_fetch(1, 16);
         drive_pix(i, 1'b1, 1);
      end
      sel_row = 5'd3;
      start_line(16, 1);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) push_fetch(1, 16);
         drive_pix(i, 1'b1, 0);
      end
      sel_en = 1'b0;

      // Full-line sweep and the first line below the text area
      start_line(8, 1);
      sweep(8, 0, 255, 1'b1);
      start_line(224, 0);
      sweep(224, 0, 15, 1'b1);
      check("no_overrun_legal", 32'(overrun), 32'd0);

      // Back-to-back pix_ce: second cell request is dropped
      start_line(0, 1);
      push_fetch(1, 0);
      pix_q.push_back(model_pix(0, 0, 1'b1));
      pix_q.push_back(-1);
      x = 8'd0; de = 1'b1; pix_ce = 1'b1;
      tick();
      x = 8'd8;
      tick();
      pix_ce = 1'b0;
      repeat (6) tick();
      check("overrun_set", 32'(overrun), 32'd1);
      repeat (20) tick();
      check("overrun_sticky", 32'(overrun), 32'd1);

      // Reset while the FSM is in FONT
      y = 8'd0;
      addr_q.push_back(0);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("midrst_ceb", 32'(ram_ceb), 32'd0);
      check("midrst_adb", 32'(ram_adb), 32'd0);
      check("midrst_pix_out", 32'(pix_out), 32'd0);
      check("midrst_overrun", 32'(overrun), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();

      addr_q.push_back(0); addr_q.push_back(16'h608);
      start_line(0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 0) push_fetch(1, 0);
         drive_pix(i, 1'b1, exp_inv[i]);
      end
      check("post_rst_overrun", 32'(overrun), 32'd0);

      repeat (8) tick();
      check("addr_q_drained", 32'(addr_q.size()), 32'd0);
      check("pix_q_drained", 32'(pix_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
